// File: rtl/uart_rx_pkg.sv
// Definitions shared by the UART receiver and transmitter: receiver state
// encoding and the default baud-accumulator settings (48 MHz, 115200 baud x16).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    RxReset,
    RxIdle,
    RxStartBit,
    RxData,
    RxStopBit,
    RxDone,
    RxBreak
  } rx_state_e;

  localparam int unsigned DEF_ACCUM_WIDTH = 16;
  localparam int unsigned DEF_ACCUM_INC   = 2517;
  localparam int unsigned DEF_STOP_BITS   = 1;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous RX pin. It resets to the
// idle-high line level so that leaving reset never looks like a start bit.
module rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic sourceClk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: a 16x oversampling tick from a free-running phase
// accumulator, mid-bit sampling, and a one-cycle valid strobe per byte.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned ACCUM_WIDTH = DEF_ACCUM_WIDTH,
  parameter int unsigned ACCUM_INC   = DEF_ACCUM_INC,
  parameter int unsigned STOP_BITS   = DEF_STOP_BITS,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       sourceClk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [ACCUM_WIDTH:0] ACC_INC = (ACCUM_WIDTH + 1)'(ACCUM_INC);

  logic                 rx_s;
  logic                 tick;
  logic [ACCUM_WIDTH:0] acc_q, acc_d;
  rx_state_e            state_q, state_d;
  logic [3:0]           sc_q, sc_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 err_q, err_d;
  logic [7:0]           rx_byte_q, rx_byte_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_busy_q, rx_busy_d;

  rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .sourceClk (sourceClk),
    .reset     (reset),
    .d         (rx_in),
    .q         (rx_s)
  );

  // The carry out of the fraction is the 16x tick; never cleared on start.
  assign tick = acc_q[ACCUM_WIDTH];

  always_comb begin
    acc_d          = {1'b0, acc_q[ACCUM_WIDTH-1:0]} + ACC_INC;
    state_d        = state_q;
    sc_d           = sc_q;
    bit_cnt_d      = bit_cnt_q;
    stop_cnt_d     = stop_cnt_q;
    shift_d        = shift_q;
    err_d          = err_q;
    rx_byte_d      = rx_byte_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    rx_busy_d      = rx_busy_q;

    case (state_q)
      RxReset: state_d = RxIdle;
      RxIdle: begin
        if (!rx_s) begin
          state_d   = RxStartBit;
          sc_d      = 4'd0;
          rx_busy_d = 1'b1;
        end
      end
      RxStartBit: begin
        if (tick) begin
          if (sc_q == 4'd7) begin
            if (rx_s) begin
              state_d   = RxIdle;
              rx_busy_d = 1'b0;
            end else begin
              state_d   = RxData;
              sc_d      = 4'd0;
              bit_cnt_d = 3'd0;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      RxData: begin
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d    = RxStopBit;
              stop_cnt_d = 2'(STOP_BITS);
              err_d      = 1'b0;
            end
          end
        end
      end
      RxStopBit: begin
        if (tick) begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            err_d      = err_q | ~rx_s;
            stop_cnt_d = stop_cnt_q - 2'd1;
            if (stop_cnt_q == 2'd1) begin
              state_d = RxDone;
            end
          end
        end
      end
      RxDone: begin
        rx_byte_d      = shift_q;
        rx_valid_d     = 1'b1;
        rx_frame_err_d = err_q;
        rx_busy_d      = 1'b0;
        state_d        = err_q ? RxBreak : RxIdle;
      end
      // A framing error may be a break; wait for the line to recover.
      RxBreak: begin
        if (rx_s) begin
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      acc_q          <= '0;
      state_q        <= RxReset;
      sc_q           <= 4'd0;
      bit_cnt_q      <= 3'd0;
      stop_cnt_q     <= 2'd0;
      shift_q        <= 8'd0;
      err_q          <= 1'b0;
      rx_byte_q      <= 8'd0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      state_q        <= state_d;
      sc_q           <= sc_d;
      bit_cnt_q      <= bit_cnt_d;
      stop_cnt_q     <= stop_cnt_d;
      shift_q        <= shift_d;
      err_q          <= err_d;
      rx_byte_q      <= rx_byte_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_busy_q      <= rx_busy_d;
    end
  end

  assign rx_byte      = rx_byte_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with one tick per clock (16 clocks per bit):
// back-to-back frames, glitch rejection, framing error, break, reset, baud skew.
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic       sourceClk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] got_byte[$];
  logic       got_err[$];
  int         got_cyc[$];

  uart_rx #(
    .ACCUM_WIDTH (4),
    .ACCUM_INC   (16),
    .STOP_BITS   (1),
    .SYNC_STAGES (2)
  ) dut (
    .sourceClk    (sourceClk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 sourceClk = ~sourceClk;

  always @(posedge sourceClk) cyc <= cyc + 1;

  always @(negedge sourceClk) begin
    if (rx_valid) begin
      got_byte.push_back(rx_byte);
      got_err.push_back(rx_frame_err);
      got_cyc.push_back(cyc);
      $display("rx byte=0x%02h frame_err=%0d cycle=%0d", rx_byte, rx_frame_err, cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge sourceClk);
  endtask

  // hp is the bit period in half-clocks; rst_bit is the frame slot (0=start)
  // during which reset is pulsed for one clock, or -1 for none.
  task automatic send_frame(input logic [7:0] b, input int hp, input logic stop_val,
                            input int rst_bit);
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      int n;
      n = ((i + 1) * hp) / 2 - (i * hp) / 2;
      rx_in = bits[i];
      for (int k = 0; k < n; k++) begin
        if (i == rst_bit && k == 3) reset = 1'b0;
        @(negedge sourceClk);
        if (i == rst_bit && k == 3) begin
          check_val("midrst_byte", 32'(rx_byte), 32'h0);
          check_val("midrst_valid", 32'(rx_valid), 32'h0);
          check_val("midrst_err", 32'(rx_frame_err), 32'h0);
          check_val("midrst_busy", 32'(rx_busy), 32'h0);
          reset = 1'b1;
        end
      end
    end
  endtask

  task automatic expect_frame(input string tag, input int idx, input logic [7:0] b,
                              input logic e);
    if (idx < got_byte.size()) begin
      check_val({tag, "_byte"}, 32'(got_byte[idx]), 32'(b));
      check_val({tag, "_ferr"}, 32'(got_err[idx]), 32'(e));
    end else begin
      check_val({tag, "_present"}, 32'(got_byte.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic [7:0] tol_bytes [3];
    int tol_hp [2];
    tol_bytes = '{8'h00, 8'hFF, 8'h96};
    tol_hp = '{33, 31};

    // Reset state
    repeat (3) @(negedge sourceClk);
    check_val("rst_byte", 32'(rx_byte), 32'h0);
    check_val("rst_valid", 32'(rx_valid), 32'h0);
    check_val("rst_ferr", 32'(rx_frame_err), 32'h0);
    check_val("rst_busy", 32'(rx_busy), 32'h0);
    check_val("rst_state", 32'(dut.state_q), 32'(RxReset));
    reset = 1'b1;
    idle(48);

    // Back-to-back 0x55, 0xA3
    base = got_byte.size();
    send_frame(8'h55, 32, 1'b1, -1);
    send_frame(8'hA3, 32, 1'b1, -1);
    idle(32);
    check_val("b2b_count", 32'(got_byte.size() - base), 32'd2);
    expect_frame("b2b_0", base, 8'h55, 1'b0);
    expect_frame("b2b_1", base + 1, 8'hA3, 1'b0);
    if (got_cyc.size() >= base + 2)
      check_val("b2b_spacing", 32'(got_cyc[base+1] - got_cyc[base]), 32'd160);

    // 6-clock glitch on idle line
    base = got_byte.size();
    rx_in = 1'b0;
    repeat (6) @(negedge sourceClk);
    rx_in = 1'b1;
    check_val("glitch_busy_hi", 32'(rx_busy), 32'h1);
    repeat (20) @(negedge sourceClk);
    check_val("glitch_busy_lo", 32'(rx_busy), 32'h0);
    check_val("glitch_state", 32'(dut.state_q), 32'(RxIdle));
    check_val("glitch_count", 32'(got_byte.size() - base), 32'd0);
    idle(32);

    // Stop bit low, then a clean frame
    base = got_byte.size();
    send_frame(8'h3C, 32, 1'b0, -1);
    idle(32);
    send_frame(8'h81, 32, 1'b1, -1);
    idle(32);
    check_val("ferr_count", 32'(got_byte.size() - base), 32'd2);
    expect_frame("ferr_0", base, 8'h3C, 1'b1);
    expect_frame("ferr_1", base + 1, 8'h81, 1'b0);

    // Line held low for 40 bit times
    base = got_byte.size();
    rx_in = 1'b0;
    repeat (640) @(negedge sourceClk);
    check_val("brk_count_low", 32'(got_byte.size() - base), 32'd1);
    check_val("brk_busy", 32'(rx_busy), 32'h0);
    idle(32);
    send_frame(8'h7E, 32, 1'b1, -1);
    idle(32);
    check_val("brk_count", 32'(got_byte.size() - base), 32'd2);
    expect_frame("brk_0", base, 8'h00, 1'b1);
    expect_frame("brk_1", base + 1, 8'h7E, 1'b0);

    // Reset pulse during data bit 4 of 0xF0
    base = got_byte.size();
    send_frame(8'hF0, 32, 1'b1, 5);
    idle(32);
    check_val("midrst_count", 32'(got_byte.size() - base), 32'd0);
    send_frame(8'h12, 32, 1'b1, -1);
    idle(32);
    check_val("midrst_next_count", 32'(got_byte.size() - base), 32'd1);
    expect_frame("midrst_next", base, 8'h12, 1'b0);

    // Baud skew +/-3%
    for (int p = 0; p < 2; p++) begin
      base = got_byte.size();
      for (int j = 0; j < 3; j++) send_frame(tol_bytes[j], tol_hp[p], 1'b1, -1);
      idle(32);
      check_val($sformatf("tol%0d_count", tol_hp[p]), 32'(got_byte.size() - base), 32'd3);
      for (int j = 0; j < 3; j++)
        expect_frame($sformatf("tol%0d_%0d", tol_hp[p], j), base + j, tol_bytes[j], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
